// File: rtl/rsp_merger_pkg.sv
// Shared widths and payload type for the response merger.
// Widths mirror mmu_param.vh, which also carries RSP_SKID_DEPTH_DEFAULT.
package rsp_merger_pkg;

    localparam int unsigned REQ_ID_WIDTH           = 8;
    localparam int unsigned ALL_PAGE_IDX_WIDTH     = 10;
    localparam int unsigned FAIL_REASON_WIDTH      = 3;
    localparam int unsigned RSP_SKID_DEPTH_DEFAULT = 4;
    localparam int unsigned RSP_ALMOST_MARGIN_DEF  = 1;

    typedef struct packed {
        logic [REQ_ID_WIDTH-1:0]       id;
        logic [ALL_PAGE_IDX_WIDTH-1:0] page_idx;
        logic                          fail;
        logic [FAIL_REASON_WIDTH-1:0]  fail_reason;
    } rsp_entry_t;

    localparam int unsigned RSP_ENTRY_WIDTH = $bits(rsp_entry_t);

endpackage

// File: rtl/rsp_skid_fifo.sv
// Small synchronous skid queue: one push and one pop per cycle, combinational head.
// A push into a full queue is only accepted when a pop frees a slot in the same cycle.
module rsp_skid_fifo
    import rsp_merger_pkg::*;
#(
    parameter int unsigned DEPTH = RSP_SKID_DEPTH_DEFAULT,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  rsp_entry_t   i_push_data,
    input  logic         i_pop,
    output rsp_entry_t   o_head_c,
    output logic         o_full_c,
    output logic         o_empty_c,
    output logic [AW:0]  o_count_c
);

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    rsp_entry_t  r_mem [DEPTH];

    logic        w_full;
    logic        w_empty;
    logic        w_do_push;
    logic        w_do_pop;

    // Extra pointer MSB separates full from empty when the index bits match.
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: pointers define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end

    assign o_head_c  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_full_c  = w_full;
    assign o_empty_c = w_empty;
    assign o_count_c = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/rsp_merger.sv
// Merges dispatcher (src0) and engine (src1) responses into one response-FIFO write port.
// Optional per-source statistics counters are enabled with RSP_MERGER_STATS_EN.
module rsp_merger
    import rsp_merger_pkg::*;
#(
    parameter int unsigned SKID_DEPTH    = RSP_SKID_DEPTH_DEFAULT,
    parameter int unsigned ALMOST_MARGIN = RSP_ALMOST_MARGIN_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          src0_write_en,
    input  logic [REQ_ID_WIDTH-1:0]       src0_id,
    input  logic [ALL_PAGE_IDX_WIDTH-1:0] src0_page_idx,
    input  logic                          src0_fail,
    input  logic [FAIL_REASON_WIDTH-1:0]  src0_fail_reason,
    input  logic                          src1_write_en,
    input  logic [REQ_ID_WIDTH-1:0]       src1_id,
    input  logic [ALL_PAGE_IDX_WIDTH-1:0] src1_page_idx,
    input  logic                          src1_fail,
    input  logic [FAIL_REASON_WIDTH-1:0]  src1_fail_reason,
    input  logic                          rsp_fifo_full,
    output logic                          rsp_fifo_write_en,
    output logic [REQ_ID_WIDTH-1:0]       rsp_id,
    output logic [ALL_PAGE_IDX_WIDTH-1:0] rsp_page_idx,
    output logic                          rsp_fail,
    output logic [FAIL_REASON_WIDTH-1:0]  rsp_fail_reason,
    output logic                          rsp_almost_full,
    output logic                          overflow_err
`ifdef RSP_MERGER_STATS_EN
    ,
    output logic [15:0]                   stat_src0_cnt,
    output logic [15:0]                   stat_src1_cnt,
    output logic [15:0]                   stat_fail_cnt,
    output logic [7:0]                    stat_drop_cnt
`endif
);

    localparam int unsigned CW = $clog2(SKID_DEPTH) + 1;
    localparam logic [CW-1:0] ALMOST_TH = CW'(SKID_DEPTH - ALMOST_MARGIN);

    rsp_entry_t    w_src0_entry;
    rsp_entry_t    w_src1_entry;
    rsp_entry_t    w_head0;
    rsp_entry_t    w_head1;
    rsp_entry_t    w_gnt_head;
    logic          w_full0;
    logic          w_full1;
    logic          w_empty0;
    logic          w_empty1;
    logic [CW-1:0] w_count0;
    logic [CW-1:0] w_count1;
    logic          w_gnt_valid;
    logic          w_gnt_sel;
    logic          w_pop0;
    logic          w_pop1;
    logic          w_drop0;
    logic          w_drop1;
    logic          w_almost;

    rsp_entry_t    r_rsp;
    logic          r_wr_en;
    logic          r_last_grant;
    logic          r_almost;
    logic          r_overflow;

    assign w_src0_entry = {src0_id, src0_page_idx, src0_fail, src0_fail_reason};
    assign w_src1_entry = {src1_id, src1_page_idx, src1_fail, src1_fail_reason};

    rsp_skid_fifo #(.DEPTH(SKID_DEPTH)) u_skid0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (src0_write_en),
        .i_push_data (w_src0_entry),
        .i_pop       (w_pop0),
        .o_head_c    (w_head0),
        .o_full_c    (w_full0),
        .o_empty_c   (w_empty0),
        .o_count_c   (w_count0)
    );

    rsp_skid_fifo #(.DEPTH(SKID_DEPTH)) u_skid1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (src1_write_en),
        .i_push_data (w_src1_entry),
        .i_pop       (w_pop1),
        .o_head_c    (w_head1),
        .o_full_c    (w_full1),
        .o_empty_c   (w_empty1),
        .o_count_c   (w_count1)
    );

    // Round-robin grant: with both queues occupied, the source that did not win last goes.
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_sel   = r_last_grant;
        if (!rsp_fifo_full) begin
            if (!w_empty0 && !w_empty1) begin
                w_gnt_valid = 1'b1;
                w_gnt_sel   = ~r_last_grant;
            end else if (!w_empty0) begin
                w_gnt_valid = 1'b1;
                w_gnt_sel   = 1'b0;
            end else if (!w_empty1) begin
                w_gnt_valid = 1'b1;
                w_gnt_sel   = 1'b1;
            end
        end
    end

    assign w_pop0     = w_gnt_valid && !w_gnt_sel;
    assign w_pop1     = w_gnt_valid &&  w_gnt_sel;
    assign w_gnt_head = w_gnt_sel ? w_head1 : w_head0;
    assign w_drop0    = src0_write_en && w_full0 && !w_pop0;
    assign w_drop1    = src1_write_en && w_full1 && !w_pop1;
    assign w_almost   = (w_count0 >= ALMOST_TH) || (w_count1 >= ALMOST_TH) || rsp_fifo_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp        <= '0;
            r_wr_en      <= 1'b0;
            r_last_grant <= 1'b1;
            r_almost     <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_wr_en    <= w_gnt_valid;
            r_almost   <= w_almost;
            r_overflow <= r_overflow | w_drop0 | w_drop1;
            if (w_gnt_valid) begin
                r_rsp        <= w_gnt_head;
                r_last_grant <= w_gnt_sel;
            end
        end
    end

    assign rsp_fifo_write_en = r_wr_en;
    assign rsp_id            = r_rsp.id;
    assign rsp_page_idx      = r_rsp.page_idx;
    assign rsp_fail          = r_rsp.fail;
    assign rsp_fail_reason   = r_rsp.fail_reason;
    assign rsp_almost_full   = r_almost;
    assign overflow_err      = r_overflow;

`ifdef RSP_MERGER_STATS_EN
    logic [15:0] r_stat_src0;
    logic [15:0] r_stat_src1;
    logic [15:0] r_stat_fail;
    logic [7:0]  r_stat_drop;
    logic [1:0]  w_drop_n;
    logic [8:0]  w_drop_sum;

    assign w_drop_n   = {1'b0, w_drop0} + {1'b0, w_drop1};
    assign w_drop_sum = {1'b0, r_stat_drop} + 9'(w_drop_n);

    // Saturating counters; both sources may drop on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_src0 <= '0;
            r_stat_src1 <= '0;
            r_stat_fail <= '0;
            r_stat_drop <= '0;
        end else begin
            if (w_pop0 && (r_stat_src0 != 16'hFFFF)) r_stat_src0 <= r_stat_src0 + 16'd1;
            if (w_pop1 && (r_stat_src1 != 16'hFFFF)) r_stat_src1 <= r_stat_src1 + 16'd1;
            if (w_gnt_valid && w_gnt_head.fail && (r_stat_fail != 16'hFFFF))
                r_stat_fail <= r_stat_fail + 16'd1;
            r_stat_drop <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
        end
    end

    assign stat_src0_cnt = r_stat_src0;
    assign stat_src1_cnt = r_stat_src1;
    assign stat_fail_cnt = r_stat_fail;
    assign stat_drop_cnt = r_stat_drop;
`endif

endmodule

// File: tb/tb_rsp_merger.sv
// Scoreboard bench for rsp_merger: expected entries queued at stimulus, checked on each write.
module tb_rsp_merger;
    import rsp_merger_pkg::*;

    logic                          clk;
    logic                          rst_n;
    logic                          src0_write_en;
    logic [REQ_ID_WIDTH-1:0]       src0_id;
    logic [ALL_PAGE_IDX_WIDTH-1:0] src0_page_idx;
    logic                          src0_fail;
    logic [FAIL_REASON_WIDTH-1:0]  src0_fail_reason;
    logic                          src1_write_en;
    logic [REQ_ID_WIDTH-1:0]       src1_id;
    logic [ALL_PAGE_IDX_WIDTH-1:0] src1_page_idx;
    logic                          src1_fail;
    logic [FAIL_REASON_WIDTH-1:0]  src1_fail_reason;
    logic                          rsp_fifo_full;
    logic                          rsp_fifo_write_en;
    logic [REQ_ID_WIDTH-1:0]       rsp_id;
    logic [ALL_PAGE_IDX_WIDTH-1:0] rsp_page_idx;
    logic                          rsp_fail;
    logic [FAIL_REASON_WIDTH-1:0]  rsp_fail_reason;
    logic                          rsp_almost_full;
    logic                          overflow_err;
`ifdef RSP_MERGER_STATS_EN
    logic [15:0] stat_src0_cnt;
    logic [15:0] stat_src1_cnt;
    logic [15:0] stat_fail_cnt;
    logic [7:0]  stat_drop_cnt;
`endif

    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_writes = 0;
    int         snap;
    rsp_entry_t sb [$];

    rsp_merger dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .src0_write_en    (src0_write_en),
        .src0_id          (src0_id),
        .src0_page_idx    (src0_page_idx),
        .src0_fail        (src0_fail),
        .src0_fail_reason (src0_fail_reason),
        .src1_write_en    (src1_write_en),
        .src1_id          (src1_id),
        .src1_page_idx    (src1_page_idx),
        .src1_fail        (src1_fail),
        .src1_fail_reason (src1_fail_reason),
        .rsp_fifo_full    (rsp_fifo_full),
        .rsp_fifo_write_en(rsp_fifo_write_en),
        .rsp_id           (rsp_id),
        .rsp_page_idx     (rsp_page_idx),
        .rsp_fail         (rsp_fail),
        .rsp_fail_reason  (rsp_fail_reason),
        .rsp_almost_full  (rsp_almost_full),
        .overflow_err     (overflow_err)
`ifdef RSP_MERGER_STATS_EN
        ,
        .stat_src0_cnt    (stat_src0_cnt),
        .stat_src1_cnt    (stat_src1_cnt),
        .stat_fail_cnt    (stat_fail_cnt),
        .stat_drop_cnt    (stat_drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic rsp_entry_t mk(input int id, input int page, input bit fail, input int reason);
        rsp_entry_t e;
        e.id          = REQ_ID_WIDTH'(id);
        e.page_idx    = ALL_PAGE_IDX_WIDTH'(page);
        e.fail        = fail;
        e.fail_reason = FAIL_REASON_WIDTH'(reason);
        return e;
    endfunction

    // Set one source's strobe and payload; caller advances time.
    task automatic drive(input int src, input rsp_entry_t e);
        if (src == 0) begin
            src0_write_en = 1'b1;
            {src0_id, src0_page_idx, src0_fail, src0_fail_reason} = e;
        end else begin
            src1_write_en = 1'b1;
            {src1_id, src1_page_idx, src1_fail, src1_fail_reason} = e;
        end
    endtask

    // Let the strobes be sampled at the next edge, then drop them.
    task automatic tick();
        @(posedge clk);
        #1;
        src0_write_en = 1'b0;
        src1_write_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Output monitor: every write must match the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && rsp_fifo_write_en) begin
            n_writes++;
            if (sb.size() == 0) begin
                chk("unexpected_write", {10'd0, rsp_id, rsp_page_idx, rsp_fail, rsp_fail_reason}, 32'hFFFF_FFFF);
            end else begin
                chk("payload", 32'({rsp_id, rsp_page_idx, rsp_fail, rsp_fail_reason}), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        rsp_entry_t e;
        rst_n = 1'b0;
        rsp_fifo_full = 1'b0;
        src0_write_en = 1'b0; src0_id = '0; src0_page_idx = '0; src0_fail = 1'b0; src0_fail_reason = '0;
        src1_write_en = 1'b0; src1_id = '0; src1_page_idx = '0; src1_fail = 1'b0; src1_fail_reason = '0;
        #12;
        chk("rst_wr_en", 32'(rsp_fifo_write_en), 0);
        chk("rst_payload", 32'({rsp_id, rsp_page_idx, rsp_fail, rsp_fail_reason}), 0);
        chk("rst_almost", 32'(rsp_almost_full), 0);
        chk("rst_ovf", 32'(overflow_err), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        // Single src0 response: write appears in the cycle after the following edge.
        e = mk(5, 7, 1'b1, 2); sb.push_back(e); drive(0, e); tick();
        @(negedge clk); chk("lat_cycle1", 32'(rsp_fifo_write_en), 0);
        @(posedge clk); #1;
        @(negedge clk); chk("lat_cycle2", 32'(rsp_fifo_write_en), 1);
        idle(4);
        chk("almost_idle", 32'(rsp_almost_full), 0);

        // Single src1 so the last winner is src1; then a same-edge pair goes src0 first.
        e = mk(6, 1, 1'b0, 0); sb.push_back(e); drive(1, e); tick(); idle(4);
        sb.push_back(mk(1, 11, 1'b0, 0)); sb.push_back(mk(2, 12, 1'b0, 0));
        drive(0, mk(1, 11, 1'b0, 0)); drive(1, mk(2, 12, 1'b0, 0)); tick();
        @(posedge clk); #1;
        @(negedge clk); chk("pair_w1", 32'(rsp_fifo_write_en), 1);
        @(posedge clk); #1;
        @(negedge clk); chk("pair_w2", 32'(rsp_fifo_write_en), 1);
        idle(4);
        // A lone src0 win leaves src0 as last winner, so the next pair goes src1 first.
        e = mk(9, 3, 1'b0, 0); sb.push_back(e); drive(0, e); tick(); idle(4);
        sb.push_back(mk(4, 14, 1'b0, 0)); sb.push_back(mk(3, 13, 1'b1, 5));
        drive(0, mk(3, 13, 1'b1, 5)); drive(1, mk(4, 14, 1'b0, 0)); tick();
        idle(5);

        // Downstream full: src1 queues 10..13, nothing written until release.
        snap = n_writes;
        rsp_fifo_full = 1'b1;
        for (int i = 10; i < 14; i++) begin
            e = mk(i, i + 100, 1'b0, 1); sb.push_back(e); drive(1, e); tick();
        end
        idle(6);
        chk("full_no_write", 32'(n_writes - snap), 0);
        chk("full_almost", 32'(rsp_almost_full), 1);
        rsp_fifo_full = 1'b0;
        @(negedge clk); chk("rel_w0", 32'(rsp_fifo_write_en), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); chk("rel_burst", 32'(rsp_fifo_write_en), 1);
        end
        @(negedge clk); chk("rel_end", 32'(rsp_fifo_write_en), 0);
        @(posedge clk); #1;
        idle(3);

        // Overflow: fifth push into a held-off queue of depth 4 is dropped.
        rsp_fifo_full = 1'b1;
        for (int i = 20; i < 25; i++) begin
            e = mk(i, i, 1'b0, 3);
            if (i < 24) sb.push_back(e);
            drive(0, e); tick();
        end
        chk("ovf_set", 32'(overflow_err), 1);
        idle(2);
        chk("ovf_sticky", 32'(overflow_err), 1);
        snap = n_writes;
        rsp_fifo_full = 1'b0;
        idle(8);
        chk("ovf_writes", 32'(n_writes - snap), 4);
        chk("ovf_sticky2", 32'(overflow_err), 1);

        // Reset with entries queued: outputs clear at once and the entries vanish.
        rsp_fifo_full = 1'b1;
        for (int i = 30; i < 33; i++) begin
            drive(0, mk(i, i, 1'b1, 1)); tick();
        end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_wr_en", 32'(rsp_fifo_write_en), 0);
        chk("arst_payload", 32'({rsp_id, rsp_page_idx, rsp_fail, rsp_fail_reason}), 0);
        chk("arst_almost", 32'(rsp_almost_full), 0);
        chk("arst_ovf", 32'(overflow_err), 0);
        rsp_fifo_full = 1'b0;
        idle(2);
        rst_n = 1'b1;
        snap = n_writes;
        idle(6);
        chk("arst_no_write", 32'(n_writes - snap), 0);
        e = mk(5, 7, 1'b1, 2); sb.push_back(e); drive(0, e); tick();
        @(negedge clk); chk("post_rst_lat1", 32'(rsp_fifo_write_en), 0);
        @(posedge clk); #1;
        @(negedge clk); chk("post_rst_lat2", 32'(rsp_fifo_write_en), 1);
        idle(4);

        // Two more src0 fails and two src1 successes since reset.
        for (int i = 0; i < 2; i++) begin
            e = mk(40 + i, 200 + i, 1'b1, 4); sb.push_back(e); drive(0, e); tick(); idle(3);
            e = mk(50 + i, 300 + i, 1'b0, 0); sb.push_back(e); drive(1, e); tick(); idle(3);
        end
`ifdef RSP_MERGER_STATS_EN
        chk("stat_src0", 32'(stat_src0_cnt), 3);
        chk("stat_src1", 32'(stat_src1_cnt), 2);
        chk("stat_fail", 32'(stat_fail_cnt), 3);
        chk("stat_drop", 32'(stat_drop_cnt), 0);
`endif
        idle(4);
        chk("sb_drained", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
